// File: rtl/adc_pkg.sv
// Shared constants, FSM state type and sample/byte helpers for the ADC frame readout.
package adc_pkg;

  localparam int unsigned NUM_TAPS_DEF = 20;
  localparam int unsigned SAMPLE_W_DEF = 14;
  localparam int unsigned BYTE_W       = 8;
  localparam logic [BYTE_W-1:0] HEADER_DEF = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    HI,
    LO,
    CSUM
  } state_t;

  // Extract tap k from a flattened default-sized tap bus (k=0 newest).
  function automatic logic [SAMPLE_W_DEF-1:0] tap_slice(
    input logic [NUM_TAPS_DEF*SAMPLE_W_DEF-1:0] taps,
    input int unsigned                          k
  );
    return taps[k*SAMPLE_W_DEF +: SAMPLE_W_DEF];
  endfunction

  // High byte of a sample already zero-extended to 16 bits.
  function automatic logic [BYTE_W-1:0] sample_hi(input logic [15:0] s);
    return s[15:8];
  endfunction

  // Low byte of a sample already zero-extended to 16 bits.
  function automatic logic [BYTE_W-1:0] sample_lo(input logic [15:0] s);
    return s[7:0];
  endfunction

endpackage

// File: rtl/adc_frame_tx.sv
// Snapshots all delay-line taps on capture and streams them as a framed,
// checksummed byte sequence over a valid/ready handshake.
module adc_frame_tx
  import adc_pkg::*;
#(
  parameter int unsigned       NUM_TAPS = NUM_TAPS_DEF,
  parameter int unsigned       SAMPLE_W = SAMPLE_W_DEF,
  parameter logic [BYTE_W-1:0] HEADER   = HEADER_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_TAPS*SAMPLE_W-1:0] taps_in,
  input  logic                         capture,
  output logic [BYTE_W-1:0]            tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic                         busy,
  output logic [BYTE_W-1:0]            drop_count
);

  localparam int unsigned IDX_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;

  state_t              r_state;
  logic [SAMPLE_W-1:0] r_snap [NUM_TAPS];
  logic [IDX_W-1:0]    r_idx;
  logic [BYTE_W-1:0]   r_csum;
  logic [BYTE_W-1:0]   r_tx_data;
  logic                r_tx_valid;
  logic                r_busy;
  logic [BYTE_W-1:0]   r_drop;

  logic                w_xfer;
  logic [IDX_W-1:0]    w_idx_dn;
  logic [15:0]         w_cur;
  logic [15:0]         w_nxt;
  logic [BYTE_W-1:0]   w_csum_nxt;

  // Handshake, next-tap index and running checksum including the byte on the bus.
  assign w_xfer     = r_tx_valid & tx_ready;
  assign w_idx_dn   = r_idx - IDX_W'(1);
  assign w_cur      = 16'(r_snap[r_idx]);
  assign w_nxt      = 16'(r_snap[w_idx_dn]);
  assign w_csum_nxt = r_csum ^ r_tx_data;

  // Frame FSM: snapshot, byte sequencing, checksum and drop counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_csum     <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_drop     <= '0;
      for (int unsigned k = 0; k < NUM_TAPS; k++) begin
        r_snap[k] <= '0;
      end
    end else begin
      // A capture during a frame (including the CSUM transfer cycle) is ignored.
      if (capture && r_busy && (r_drop != 8'hFF)) begin
        r_drop <= r_drop + 8'd1;
      end

      case (r_state)
        IDLE: begin
          if (capture) begin
            for (int unsigned k = 0; k < NUM_TAPS; k++) begin
              r_snap[k] <= taps_in[k*SAMPLE_W +: SAMPLE_W];
            end
            r_csum     <= '0;
            r_idx      <= IDX_W'(NUM_TAPS - 1);
            r_tx_data  <= HEADER;
            r_tx_valid <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= HDR;
          end
        end
        HDR: begin
          if (w_xfer) begin
            r_tx_data <= sample_hi(w_cur);
            r_state   <= HI;
          end
        end
        HI: begin
          if (w_xfer) begin
            r_csum    <= w_csum_nxt;
            r_tx_data <= sample_lo(w_cur);
            r_state   <= LO;
          end
        end
        LO: begin
          if (w_xfer) begin
            r_csum <= w_csum_nxt;
            if (r_idx == '0) begin
              r_tx_data <= w_csum_nxt;
              r_state   <= CSUM;
            end else begin
              r_idx     <= w_idx_dn;
              r_tx_data <= sample_hi(w_nxt);
              r_state   <= HI;
            end
          end
        end
        CSUM: begin
          if (w_xfer) begin
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_tx_valid <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign tx_data    = r_tx_data;
  assign tx_valid   = r_tx_valid;
  assign busy       = r_busy;
  assign drop_count = r_drop;

endmodule

// File: tb/tb_adc_frame_tx.sv
// Self-checking bench for adc_frame_tx: queue-based frame model plus directed
// and randomized stimulus (ramp, full-scale, backpressure, drops, isolation, reset).
module tb_adc_frame_tx;
  import adc_pkg::*;

  localparam int unsigned NT = NUM_TAPS_DEF;
  localparam int unsigned SW = SAMPLE_W_DEF;
  localparam int unsigned FL = 2*NT + 2;

  typedef logic [7:0] frame_t [FL];

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NT*SW-1:0] taps_in = '0;
  logic             capture = 1'b0;
  logic             tx_ready = 1'b0;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             busy;
  logic [7:0]       drop_count;

  adc_frame_tx dut (
    .clk        (clk),
    .rst        (rst),
    .taps_in    (taps_in),
    .capture    (capture),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  int         m_drop   = 0;
  logic       m_busy   = 1'b0;
  logic       hold_pend = 1'b0;
  logic [7:0] hold_data = '0;
  frame_t     mf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame from the spec's rules: header, oldest-first hi/lo bytes, XOR of sample bytes.
  function automatic frame_t make_frame(input logic [NT*SW-1:0] t);
    frame_t      f;
    int unsigned s;
    logic [7:0]  cs;
    cs   = 8'h00;
    f[0] = HEADER_DEF;
    for (int i = 0; i < NT; i++) begin
      s          = 32'(tap_slice(t, NT - 1 - i));
      f[1 + 2*i] = 8'(s / 256);
      f[2 + 2*i] = 8'(s % 256);
      cs         = cs ^ f[1 + 2*i] ^ f[2 + 2*i];
    end
    f[FL-1] = cs;
    return f;
  endfunction

  // Model and compare on every falling edge (inputs change just after rising edges).
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_drop    = 0;
      hold_pend = 1'b0;
    end else begin
      m_busy = (exp_q.size() != 0);
      check("busy", 32'(busy), 32'(m_busy));
      check("tx_valid", 32'(tx_valid), 32'(m_busy));
      check("drop_count", 32'(drop_count), 32'(m_drop));
      if (hold_pend) check("hold_data", 32'(tx_data), 32'(hold_data));
      hold_pend = tx_valid && !tx_ready;
      hold_data = tx_data;
      if (tx_valid && tx_ready && exp_q.size() != 0) begin
        check("tx_byte", 32'(tx_data), 32'(exp_q[0]));
        void'(exp_q.pop_front());
      end
      if (capture) begin
        if (!m_busy) begin
          mf = make_frame(taps_in);
          for (int i = 0; i < FL; i++) exp_q.push_back(mf[i]);
        end else if (m_drop < 255) begin
          m_drop++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ramp();
    for (int k = 0; k < NT; k++) taps_in[k*SW +: SW] = SW'(100 + k);
  endtask

  task automatic set_random();
    for (int k = 0; k < NT; k++) taps_in[k*SW +: SW] = SW'($urandom);
  endtask

  task automatic pulse_capture();
    capture = 1'b1;
    step();
    capture = 1'b0;
  endtask

  // mode 0: hold inputs, 1: random 30% ready, 2: new random taps every cycle
  task automatic wait_idle(input int mode, input int limit);
    int c;
    c = 0;
    while (busy && c < limit) begin
      if (mode == 1) tx_ready = ($urandom_range(0, 99) < 30);
      if (mode == 2) set_random();
      step();
      c++;
    end
    check("wait_idle", 32'(busy), 32'd0);
    tx_ready = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_t     pf;
    logic [NT*SW-1:0] t;
    int         cnt;

    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("reset_tx_data", 32'(tx_data), 32'h00);
    check("reset_tx_valid", 32'(tx_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_drop", 32'(drop_count), 32'd0);

    // Pin the model with hand-computed frames.
    for (int k = 0; k < NT; k++) t[k*SW +: SW] = SW'(100 + k);
    pf = make_frame(t);
    check("model_ramp_hdr", 32'(pf[0]), 32'hA5);
    check("model_ramp_hi19", 32'(pf[1]), 32'h00);
    check("model_ramp_lo19", 32'(pf[2]), 32'h77);
    check("model_ramp_lo0", 32'(pf[FL-2]), 32'h64);
    check("model_ramp_csum", 32'(pf[FL-1]), 32'h00);
    t = '0;
    t[0 +: SW] = SW'(16'h1234);
    pf = make_frame(t);
    check("model_one_hi", 32'(pf[FL-3]), 32'h12);
    check("model_one_csum", 32'(pf[FL-1]), 32'h26);
    for (int k = 0; k < NT; k++) t[k*SW +: SW] = SW'(16'h3FFF);
    pf = make_frame(t);
    check("model_fs_hi", 32'(pf[1]), 32'h3F);
    check("model_fs_lo", 32'(pf[2]), 32'hFF);
    check("model_fs_csum", 32'(pf[FL-1]), 32'h00);

    // Ramp, zero-bubble: busy high for exactly 42 cycles.
    set_ramp();
    tx_ready = 1'b1;
    pulse_capture();
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (busy) cnt++;
      else break;
    end
    check("ramp_busy_cycles", 32'(cnt), 32'(FL));

    // Full-scale.
    step();
    for (int k = 0; k < NT; k++) taps_in[k*SW +: SW] = SW'(16'h3FFF);
    pulse_capture();
    wait_idle(0, 200);

    // Backpressure with ~30% ready duty.
    set_ramp();
    tx_ready = ($urandom_range(0, 99) < 30);
    pulse_capture();
    wait_idle(1, 3000);

    // Drops: three mid-frame, one on the CSUM transfer cycle, then an accepted capture.
    set_ramp();
    tx_ready = 1'b1;
    pulse_capture();
    for (int i = 0; i <= 42; i++) begin
      capture = ((i + 1) == 5) || ((i + 1) == 10) || ((i + 1) == 15) ||
                ((i + 1) == 42) || ((i + 1) == 43);
      step();
    end
    capture = 1'b0;
    check("drop_count_4", 32'(drop_count), 32'd4);
    check("second_frame_busy", 32'(busy), 32'd1);
    wait_idle(0, 200);

    // Snapshot isolation: taps change every cycle after capture.
    set_random();
    pulse_capture();
    wait_idle(2, 200);

    // Reset after byte 10 of a frame.
    set_ramp();
    pulse_capture();
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_tx_valid", 32'(tx_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_drop", 32'(drop_count), 32'd0);
    check("midrst_tx_data", 32'(tx_data), 32'h00);
    pulse_capture();
    wait_idle(0, 200);

    // Random frames with random backpressure.
    for (int f = 0; f < 4; f++) begin
      set_random();
      pulse_capture();
      wait_idle(1, 3000);
      step();
    end

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
